// File: rtl/issue_select_pkg.sv
// rtl/issue_select_pkg.sv - shared core parameters and entry type for issue selection
package issue_select_pkg;
   localparam int SIZE  = 4;
   localparam int IDX_W = $clog2(SIZE);
   localparam int CNT_W = $clog2(SIZE + 1);

   typedef logic [3:0] entry_t;
endpackage

// File: rtl/issue_select_if.sv
// rtl/issue_select_if.sv - issued-entry output handshake between issue_select and downstream
import issue_select_pkg::*;

interface issue_select_if #(
   parameter int  Size = SIZE,
   parameter type T    = entry_t
);
   localparam int IW = (Size > 1) ? $clog2(Size) : 1;

   logic          o_valid;
   T              o_data;
   logic [IW-1:0] o_index;
   logic          i_accept;

   modport source (output o_valid, output o_data, output o_index, input i_accept);
   modport sink   (input o_valid, input o_data, input o_index, output i_accept);
endinterface

// File: rtl/issue_select_priority_pick.sv
// rtl/issue_select_priority_pick.sv - lowest-set-bit finder returning one-hot, index and found
module priority_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_index,
   output logic          o_found
);
   logic [N-1:0]  w_onehot;
   logic [IW-1:0] w_index;

   // Scan from the top so the last hit written is the lowest set bit.
   always_comb begin
      w_index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            w_index = IW'(i);
         end
      end
   end

   assign w_onehot = i_req & (~i_req + N'(1));
   assign o_onehot = w_onehot;
   assign o_index  = w_index;
   assign o_found  = |i_req;
endmodule

// File: rtl/issue_select.sv
// rtl/issue_select.sv - picks the oldest eligible queue entry into a one-deep output register
module issue_select
   import issue_select_pkg::*;
#(
   parameter int  Size = SIZE,
   parameter type T    = entry_t
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [$clog2(Size+1)-1:0]    i_size,
   input  T                             i_data [Size],
   input  logic [Size-1:0]              i_ready,
   input  logic                         i_flush,
   output logic [Size-1:0]              o_pop,
   output logic [15:0]                  o_issued,
   issue_select_if.source               iss
);
   localparam int IW = (Size > 1) ? $clog2(Size) : 1;
   localparam int SW = $clog2(Size + 1);

   logic [Size-1:0] w_elig;
   logic [Size-1:0] w_onehot;
   logic [IW-1:0]   w_idx;
   logic            w_found;
   logic            w_slot_free;
   logic            w_capture;
   logic            w_done;

   logic            r_valid;
   T                r_data;
   logic [IW-1:0]   r_index;
   logic [15:0]     r_issued;

   // Entries beyond the live count are stale and must never be picked.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < Size; i++) begin
         w_elig[i] = i_ready[i] && (SW'(i) < i_size);
      end
   end

   priority_pick #(.N(Size), .IW(IW)) u_pick (
      .i_req    (w_elig),
      .o_onehot (w_onehot),
      .o_index  (w_idx),
      .o_found  (w_found)
   );

   assign w_done      = r_valid && iss.i_accept;
   assign w_slot_free = !r_valid || iss.i_accept;
   assign w_capture   = i_rst_n && !i_flush && w_slot_free && w_found;
   assign o_pop       = w_capture ? w_onehot : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_index  <= '0;
         r_issued <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else begin
         if (w_capture) begin
            r_data  <= i_data[w_idx];
            r_index <= w_idx;
            r_valid <= 1'b1;
         end else if (w_done) begin
            r_valid <= 1'b0;
         end
         if (w_done) begin
            r_issued <= r_issued + 16'd1;
         end
      end
   end

   assign iss.o_valid = r_valid;
   assign iss.o_data  = r_data;
   assign iss.o_index = r_index;
   assign o_issued    = r_issued;
endmodule

// File: tb/tb_issue_select.sv
// tb/tb_issue_select.sv - scoreboard bench for issue_select
module tb_issue_select;
   import issue_select_pkg::*;

   logic         i_clk;
   logic         i_rst_n;
   logic [2:0]   i_size;
   entry_t       i_data [4];
   logic [3:0]   i_ready;
   logic         i_flush;
   logic [3:0]   o_pop;
   logic [15:0]  o_issued;

   issue_select_if bus ();

   issue_select dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_size   (i_size),
      .i_data   (i_data),
      .i_ready  (i_ready),
      .i_flush  (i_flush),
      .o_pop    (o_pop),
      .o_issued (o_issued),
      .iss      (bus)
   );

   int tests  = 0;
   int failed = 0;
   logic [5:0] sb [$];

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_data(input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3);
      i_data[0] = d0;
      i_data[1] = d1;
      i_data[2] = d2;
      i_data[3] = d3;
   endtask

   // Expect a capture this cycle: check the pop and queue the entry for the monitor.
   task automatic expect_pop(input string name, input logic [3:0] pop, input logic [3:0] d,
                             input logic [1:0] idx);
      #1;
      chk(name, {28'b0, o_pop}, {28'b0, pop});
      sb.push_back({d, idx});
   endtask

   task automatic expect_no_pop(input string name);
      #1;
      chk(name, {28'b0, o_pop}, 32'h0);
   endtask

   // Monitor: the held entry is checked every cycle it is presented, retired on accept or flush.
   always @(negedge i_clk) begin
      if (i_rst_n && bus.o_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            chk("out_data",  {28'b0, bus.o_data},  {28'b0, sb[0][5:2]});
            chk("out_index", {30'b0, bus.o_index}, {30'b0, sb[0][1:0]});
            if (bus.i_accept || i_flush) void'(sb.pop_front());
         end
      end
   end

   initial begin
      i_rst_n      = 1'b0;
      i_size       = 3'd0;
      i_ready      = 4'b0000;
      i_flush      = 1'b0;
      bus.i_accept = 1'b0;
      set_data(4'd0, 4'd0, 4'd0, 4'd0);
      #2;
      chk("rst_valid",  {31'b0, bus.o_valid}, 32'd0);
      chk("rst_pop",    {28'b0, o_pop}, 32'd0);
      chk("rst_issued", {16'b0, o_issued}, 32'd0);
      step();
      step();
      i_rst_n = 1'b1;

      for (int c = 0; c < 3; c++) begin
         i_ready = 4'b1111;
         expect_no_pop("size0_pop");
         step();
         chk("size0_valid",  {31'b0, bus.o_valid}, 32'd0);
         chk("size0_issued", {16'b0, o_issued}, 32'd0);
      end

      i_size = 3'd4;
      set_data(4'd0, 4'd2, 4'd4, 4'd6);
      i_ready = 4'b1010;
      bus.i_accept = 1'b1;
      expect_pop("first_pop", 4'b0010, 4'd2, 2'd1);
      step();
      chk("first_valid", {31'b0, bus.o_valid}, 32'd1);

      bus.i_accept = 1'b0;
      for (int c = 0; c < 3; c++) begin
         expect_no_pop("bp_pop");
         step();
         chk("bp_valid",  {31'b0, bus.o_valid}, 32'd1);
         chk("bp_issued", {16'b0, o_issued}, 32'd0);
      end
      bus.i_accept = 1'b1;
      i_ready = 4'b1000;
      expect_pop("acc_cap_pop", 4'b1000, 4'd6, 2'd3);
      step();
      chk("acc_cap_issued", {16'b0, o_issued}, 32'd1);
      chk("acc_cap_valid",  {31'b0, bus.o_valid}, 32'd1);

      i_size = 3'd2;
      i_ready = 4'b1100;
      expect_no_pop("size2_pop");
      step();
      chk("drain_valid",  {31'b0, bus.o_valid}, 32'd0);
      chk("drain_issued", {16'b0, o_issued}, 32'd2);

      i_size = 3'd4;
      i_ready = 4'b1111;
      set_data(4'd9, 4'd10, 4'd11, 4'd12);
      bus.i_accept = 1'b0;
      expect_pop("pre_flush_pop", 4'b0001, 4'd9, 2'd0);
      step();
      i_flush = 1'b1;
      bus.i_accept = 1'b1;
      expect_no_pop("flush_pop");
      step();
      chk("flush_valid",  {31'b0, bus.o_valid}, 32'd0);
      chk("flush_issued", {16'b0, o_issued}, 32'd2);
      i_flush = 1'b0;

      i_ready = 4'b0100;
      expect_pop("tp_pop0", 4'b0100, 4'd11, 2'd2);
      step();
      i_ready = 4'b0010;
      expect_pop("tp_pop1", 4'b0010, 4'd10, 2'd1);
      step();
      chk("tp_issued", {16'b0, o_issued}, 32'd3);
      i_ready = 4'b0000;
      expect_no_pop("tp_idle_pop");
      step();
      chk("tp_end_valid",  {31'b0, bus.o_valid}, 32'd0);
      chk("tp_end_issued", {16'b0, o_issued}, 32'd4);

      i_size = 3'd3;
      i_ready = 4'b1000;
      expect_no_pop("size3_pop");
      i_size = 3'd4;
      bus.i_accept = 1'b0;
      expect_pop("size4_top_pop", 4'b1000, 4'd12, 2'd3);
      step();
      chk("held_valid", {31'b0, bus.o_valid}, 32'd1);

      i_ready = 4'b0000;
      #2;
      i_rst_n = 1'b0;
      sb.delete();
      #1;
      chk("async_rst_valid",  {31'b0, bus.o_valid}, 32'd0);
      chk("async_rst_data",   {28'b0, bus.o_data}, 32'd0);
      chk("async_rst_index",  {30'b0, bus.o_index}, 32'd0);
      chk("async_rst_issued", {16'b0, o_issued}, 32'd0);
      chk("async_rst_pop",    {28'b0, o_pop}, 32'd0);
      #2;
      i_rst_n = 1'b1;
      step();

      i_ready = 4'b0001;
      bus.i_accept = 1'b1;
      expect_pop("post_rst_pop", 4'b0001, 4'd9, 2'd0);
      step();
      chk("post_rst_valid", {31'b0, bus.o_valid}, 32'd1);
      i_ready = 4'b0000;
      step();
      chk("post_rst_drain",  {31'b0, bus.o_valid}, 32'd0);
      chk("post_rst_issued", {16'b0, o_issued}, 32'd1);
      step();
      chk("sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/issue_select.md
ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 Parameter: Size, 4, number of queue entries observed.
REQ-002 Parameter: T, bit [3:0], entry payload type (matches the upstream queue's T).
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_size  input  $clog2(Size+1)  count of valid queue entries; entries 0..i_size-1 valid, index 0 oldest.
REQ-006 i_data  input  T[Size]  parallel queue entries.
REQ-007 i_ready  input  1[Size]  per-entry "eligible to issue" flags from the scoreboard.
REQ-008 i_flush  input  1  discard held output and suppress selection this cycle.
REQ-009 i_accept  input  1  downstream ready.
REQ-010 o_pop  output  1[Size]  per-entry pop to the queue, combinational, at most one bit set.
REQ-011 o_valid  output  1  output register holds an issued entry.
REQ-012 o_data  output  T  issued payload.
REQ-013 o_index  output  $clog2(Size)  queue index the payload was taken from.
REQ-014 o_issued  output  16  count of completed handshakes (o_valid && i_accept).

Function
REQ-015 Candidate SHALL be the lowest index i with i < i_size and i_ready[i]; none if no such i.
REQ-016 Slot free SHALL be defined as !o_valid || i_accept.
REQ-017 When slot free, candidate exists and !i_flush, o_pop[i] SHALL be 1 that cycle and on the edge o_data<=i_data[i], o_index<=i, o_valid<=1.
REQ-018 Otherwise o_pop SHALL be all zero; no entry is ever popped without being captured in the same edge.
REQ-019 When o_valid && i_accept and no capture occurs, o_valid SHALL clear on the edge.
REQ-020 When o_valid && !i_accept and !i_flush, o_data/o_index/o_valid SHALL hold unchanged (back-pressure).
REQ-021 Accept and capture in the same cycle SHALL both take effect: throughput one issue per cycle, latency one cycle from pop to o_valid.
REQ-022 i_flush SHALL clear o_valid on the edge, force o_pop to zero, and take priority over accept and capture; o_issued does not increment on a flush cycle.
REQ-023 Entries at index >= i_size SHALL be ignored regardless of i_ready; i_size = 0 yields no candidate.
REQ-024 o_issued SHALL increment by 1 per o_valid && i_accept && !i_flush cycle and wrap from 16'hFFFF to 0.
REQ-025 o_data and o_index SHALL not change while o_valid is 0 except on capture.

Reset
REQ-026 Assertion of i_rst_n low SHALL immediately clear o_valid, o_data, o_index and o_issued to 0, independent of i_clk.
REQ-027 o_pop SHALL be all zero while i_rst_n is low; a held entry is lost on reset mid-operation (queue is reset concurrently).
REQ-028 First capture SHALL be possible on the first rising edge after i_rst_n deasserts.

Structure
REQ-029 Index width and the default entry type SHALL live in the shared core package alongside the queue's parameters.
REQ-030 Candidate selection SHALL be a sub-module priority_pick (Size-wide lowest-set-bit finder returning one-hot, index and found); the rest is one sequential process plus pop gating.

Verification
REQ-031 Reset, i_size=0 -> o_valid=0, o_pop=0000, o_issued=0 for 3 cycles.
REQ-032 i_size=4, data {0,2,4,6}, i_ready=1010 (entries 1,3), i_accept=1 -> o_pop=0010, next cycle o_data=2, o_index=1, o_valid=1.
REQ-033 o_valid=1, i_accept=0 for 3 cycles, candidate present -> o_pop=0000, o_data held; i_accept=1 -> capture and accept same edge, o_issued+1.
REQ-034 i_size=2, i_ready=1100 -> no candidate, o_pop=0000, o_valid clears after accept.
REQ-035 i_flush=1 with o_valid=1 and candidate present -> o_pop=0000, o_valid=0 next cycle, o_issued unchanged.
REQ-036 i_rst_n pulsed low between edges while o_valid=1 -> o_valid, o_data, o_index, o_issued read 0 before the next edge.
